avalon_master_arbiter: RTL and testbench

- Shares the single Avalon-MM master port (SDRAM and Avalon UART path) between two requesters.
- Requester 0 is the CPU's av_ad_hi/av_ad_lo/av_data register interface. Requester 1 is a DMA-style engine, e.g. a future hardware string-to-UART pump.
- Round-robin arbitration; one transaction in flight at a time.
- Each requester uses a level-request / single-cycle-ack handshake, so CPU code never drives the Avalon port directly.

---
 rtl/avalon_master_arbiter.sv | 151 +++++++++++++++
 tb/tb_avalon_master_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between two requesters.
// Optional bus-stall watchdog enabled by defining AVALON_ARB_TIMEOUT_EN.
module avalon_master_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              sysclk,
  input  logic              sysreset,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ack,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              bus_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;

  // A zero-cycle watchdog would abort every transaction before it starts.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   pick_c;

  // Winner selection: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    pick_c = 1'b0;
    if (r0_req && r1_req) begin
      pick_c = ~last_grant;
    end else if (r1_req) begin
      pick_c = 1'b1;
    end
  end

`ifdef AVALON_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit_c;
  logic             bus_timeout_q;

  // Counter holds the number of stalled BUS edges already seen.
  assign to_hit_c    = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_timeout = bus_timeout_q;
`else
  assign bus_timeout = 1'b0;
`endif

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      r0_rdata      <= '0;
      r1_rdata      <= '0;
      r0_ack        <= 1'b0;
      r1_ack        <= 1'b0;
`ifdef AVALON_ARB_TIMEOUT_EN
      to_cnt        <= '0;
      bus_timeout_q <= 1'b0;
`endif
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            grant         <= pick_c;
            last_grant    <= pick_c;
            avm_address   <= pick_c ? r1_addr  : r0_addr;
            avm_writedata <= pick_c ? r1_wdata : r0_wdata;
            avm_write     <= pick_c ? r1_write : r0_write;
            avm_read      <= pick_c ? ~r1_write : ~r0_write;
`ifdef AVALON_ARB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
            state         <= BUS;
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (avm_read) begin
              if (grant) begin
                r1_rdata <= avm_readdata;
              end else begin
                r0_rdata <= avm_readdata;
              end
            end
            state <= ACK;
          end
`ifdef AVALON_ARB_TIMEOUT_EN
          // Abort a stuck slave: poison read data and complete with a normal ack.
          else if (to_hit_c) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (avm_read) begin
              if (grant) begin
                r1_rdata <= DATA_W'(16'hdead);
              end else begin
                r0_rdata <= DATA_W'(16'hdead);
              end
            end
            bus_timeout_q <= 1'b1;
            state         <= ACK;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        ACK: begin
          if (grant) begin
            r1_ack <= 1'b1;
          end else begin
            r0_ack <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Testbench for avalon_master_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_avalon_master_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned TO_CYC = 8;
`ifdef AVALON_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              sysclk   = 1'b0;
  logic              sysreset = 1'b1;
  logic              req   [2];
  logic              wr    [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];
  logic              ack   [2];
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata    = '0;
  logic              avm_waitrequest = 1'b1;
  logic              bus_timeout;

  avalon_master_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .sysclk         (sysclk),
    .sysreset       (sysreset),
    .r0_req         (req[0]),
    .r0_write       (wr[0]),
    .r0_addr        (addr[0]),
    .r0_wdata       (wdata[0]),
    .r0_rdata       (rdata[0]),
    .r0_ack         (ack[0]),
    .r1_req         (req[1]),
    .r1_write       (wr[1]),
    .r1_addr        (addr[1]),
    .r1_wdata       (wdata[1]),
    .r1_rdata       (rdata[1]),
    .r1_ack         (ack[1]),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .bus_timeout    (bus_timeout)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who was served last, what each requester last read, sticky timeout.
  int                m_last;
  logic [DATA_W-1:0] m_rdata [2];
  logic              m_to;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge sysclk) begin
    if (!sysreset) check_eq("ack_exclusive", 32'(ack[0] & ack[1]), 32'd0);
  end

  task automatic step();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic set_req(input int k, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
  endtask

  task automatic rand_req(input int k);
    set_req(k, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
  endtask

  task automatic model_reset();
    m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0; m_to = 1'b0;
  endtask

  task automatic apply_reset();
    sysreset = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    avm_waitrequest = 1'b1;
    step();
    step();
    sysreset = 1'b0;
    model_reset();
  endtask

  // Runs one transaction starting at a negedge with requests already driven; ends at
  // the negedge of the ack cycle. The slave stalls for 'waits' edges then returns rd.
  task automatic do_txn(input int waits, input logic [DATA_W-1:0] rd, input bit drop,
                        output int win);
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                tmo;
    int                hold;
    if (req[0] && req[1]) win = (m_last == 0) ? 1 : 0;
    else                  win = req[0] ? 0 : 1;
    w = wr[win]; a = addr[win]; d = wdata[win];
    tmo  = TO_EN && (waits >= int'(TO_CYC));
    hold = tmo ? int'(TO_CYC) - 1 : waits;
    avm_waitrequest = 1'b1;
    avm_readdata    = DATA_W'($urandom);
    step();
    check_eq("grant_read",  32'(avm_read),  32'(!w));
    check_eq("grant_write", 32'(avm_write), 32'(w));
    check_eq("grant_addr",  avm_address,    a);
    check_eq("grant_wdata", 32'(avm_writedata), 32'(d));
    for (int i = 0; i < hold; i++) begin
      if (drop && i == 0) req[win] = 1'b0;
      step();
      check_eq("hold_strobe", 32'({avm_read, avm_write}), 32'({!w, w}));
      check_eq("hold_addr",   avm_address, a);
      check_eq("hold_wdata",  32'(avm_writedata), 32'(d));
      check_eq("hold_noack",  32'({ack[0], ack[1]}), 32'd0);
    end
    if (!tmo) begin
      avm_waitrequest = 1'b0;
      avm_readdata    = rd;
    end
    step();
    check_eq("done_strobe", 32'({avm_read, avm_write}), 32'd0);
    check_eq("done_noack",  32'({ack[0], ack[1]}), 32'd0);
    avm_waitrequest = 1'b1;
    avm_readdata    = DATA_W'($urandom);
    step();
    check_eq("ack_winner", 32'(ack[win]),     32'd1);
    check_eq("ack_other",  32'(ack[1 - win]), 32'd0);
    if (!w) m_rdata[win] = tmo ? DATA_W'(16'hdead) : rd;
    if (tmo) m_to = 1'b1;
    m_last = win;
    check_eq("rdata0",      32'(rdata[0]),    32'(m_rdata[0]));
    check_eq("rdata1",      32'(rdata[1]),    32'(m_rdata[1]));
    check_eq("bus_timeout", 32'(bus_timeout), 32'(m_to));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int win;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    model_reset();
    @(negedge sysclk);
    #1;
    check_eq("rst_strobe", 32'({avm_read, avm_write}), 32'd0);
    check_eq("rst_addr",   avm_address, 32'd0);
    check_eq("rst_wdata",  32'(avm_writedata), 32'd0);
    check_eq("rst_ack",    32'({ack[0], ack[1]}), 32'd0);
    check_eq("rst_rdata",  32'({rdata[0], rdata[1]}), 32'd0);
    check_eq("rst_tmo",    32'(bus_timeout), 32'd0);
    apply_reset();

    // r0 read at 0x20 with no stall
    set_req(0, 1'b0, 32'h20, 16'h0);
    do_txn(0, 16'h6789, 1'b0, win);
    req[0] = 1'b0;
    check_eq("a_win",   32'(win), 32'd0);
    check_eq("a_rdata", 32'(rdata[0]), 32'h6789);

    // r1 write at 0x40 stalled for five edges
    set_req(1, 1'b1, 32'h40, 16'h1234);
    do_txn(5, 16'hbeef, 1'b0, win);
    req[1] = 1'b0;
    check_eq("b_win",   32'(win), 32'd1);
    check_eq("b_rdata", 32'(rdata[1]), 32'h0);

    // Both held high across four transactions alternate starting with r0
    apply_reset();
    set_req(0, 1'b0, 32'h100, 16'h0);
    set_req(1, 1'b1, 32'h200, 16'h55aa);
    for (int i = 0; i < 4; i++) begin
      do_txn(i, 16'(16'h1000 + i), 1'b0, win);
      check_eq("rr_order", 32'(win), 32'(i % 2));
    end
    req[0] = 1'b0; req[1] = 1'b0;

    // Requester withdraws mid-stall; transaction still completes
    set_req(0, 1'b1, 32'h300, 16'h7777);
    do_txn(4, 16'h0, 1'b1, win);
    check_eq("drop_win", 32'(win), 32'd0);
    step();
    check_eq("drop_idle", 32'({avm_read, avm_write}), 32'd0);

    // Reset during the second BUS cycle of an r0 read
    set_req(0, 1'b0, 32'h80, 16'h0);
    avm_waitrequest = 1'b1;
    step();
    step();
    check_eq("mid_pre_read", 32'(avm_read), 32'd1);
    sysreset = 1'b1;
    #1;
    check_eq("mid_async_read", 32'(avm_read), 32'd0);
    check_eq("mid_async_addr", avm_address, 32'd0);
    req[0] = 1'b0;
    @(negedge sysclk);
    step();
    check_eq("mid_noack", 32'({ack[0], ack[1]}), 32'd0);
    sysreset = 1'b0;
    model_reset();
    step();
    check_eq("mid_idle", 32'({avm_read, avm_write, ack[0], ack[1]}), 32'd0);
    set_req(0, 1'b0, 32'h84, 16'h0);
    set_req(1, 1'b0, 32'h88, 16'h0);
    do_txn(1, 16'h4242, 1'b0, win);
    check_eq("tie_after_rst", 32'(win), 32'd0);
    req[0] = 1'b0;
    do_txn(0, 16'h2424, 1'b0, win);
    req[1] = 1'b0;

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int k;
      if (!req[0] && !req[1]) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          check_eq("idle_strobe", 32'({avm_read, avm_write}), 32'd0);
        end
        k = $urandom_range(0, 2);
        if (k != 1) rand_req(0);
        if (k != 0) rand_req(1);
      end
      do_txn($urandom_range(0, 5), DATA_W'($urandom), 1'b0, win);
      if ($urandom_range(0, 1) == 1) rand_req(win);
      else req[win] = 1'b0;
      if (!req[1 - win] && $urandom_range(0, 3) == 0) rand_req(1 - win);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    step();

`ifdef AVALON_ARB_TIMEOUT_EN
    // Slave stuck: r1 read aborts after the watchdog limit
    set_req(1, 1'b0, 32'h500, 16'h0);
    do_txn(1000, 16'h0, 1'b0, win);
    req[1] = 1'b0;
    check_eq("to_rdata", 32'(rdata[1]), 32'hdead);
    check_eq("to_flag",  32'(bus_timeout), 32'd1);
    set_req(0, 1'b1, 32'h504, 16'h1);
    do_txn(2, 16'h0, 1'b0, win);
    req[0] = 1'b0;
    check_eq("to_sticky", 32'(bus_timeout), 32'd1);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
